// File: rtl/stage_sequencer_pkg.sv
// Shared constants for the stage sequencer: PC mux select codes, RV32I opcodes,
// FSM state type and opcode classification helpers.
package stage_sequencer_pkg;

  localparam int unsigned SEL_PC_WIDTH = 3;

  typedef enum logic [SEL_PC_WIDTH-1:0] {
    PC_SEL_PLUS4  = 3'd0,
    PC_SEL_BRANCH = 3'd1,
    PC_SEL_JALR   = 3'd2,
    PC_SEL_MTVEC  = 3'd3,
    PC_SEL_MEPC   = 3'd4
  } pc_sel_e;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_COMMIT,
    ST_HALT
  } state_e;

  function automatic logic opcode_legal(input logic [6:0] op);
    logic legal;
    unique case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic opcode_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/stage_sequencer_watchdog.sv
// Memory-wait watchdog: 8-bit cycle counter that flags the last permitted
// MEM_WAIT cycle so the sequencer can abandon a hung memory access.
module seq_watchdog
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tmo_cnt <= '0;
    end else if (enable) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign expire = enable && (tmo_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM for the 3-stage core: FETCH, EXEC, optional MEM_WAIT,
// COMMIT, plus HALT with run/step debug control, retire counter and watchdog.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memory_done,
  input  logic [SEL_PC_WIDTH-1:0] pc_sel,
  input  logic                    br_taken,
  input  logic [31:0]             ir,
  input  logic [31:0]             next_pc,
  input  logic                    halt_req,
  input  logic                    run_req,
  input  logic                    step_req,
  output logic                    c_fetch_stall,
  output logic [SEL_PC_WIDTH-1:0] c_pc_sel,
  output logic                    c_br_taken,
  output logic [31:0]             c_next_pc,
  output logic                    halted,
  output logic                    retire,
  output logic [31:0]             instret,
  output logic                    err_timeout,
  output logic                    err_illegal
);

  state_e                  state;
  logic [31:0]             pc_q;
  logic [SEL_PC_WIDTH-1:0] sel_q;
  logic                    taken_q;
  logic                    step_q;
  logic                    wd_expire;

  seq_watchdog #(
    .LIMIT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_MEM_WAIT),
    .enable (state == ST_MEM_WAIT),
    .expire (wd_expire)
  );

  // Only COMMIT lets the datapath PC advance; every other state recirculates pc_q.
  assign c_next_pc = (state == ST_COMMIT) ? next_pc : pc_q;
  assign c_pc_sel  = sel_q;

  // Registered outputs are assigned for the state being entered, so they are
  // valid throughout that state rather than one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= START_HALTED ? ST_HALT : ST_FETCH;
      pc_q          <= RESET_PC;
      sel_q         <= PC_SEL_PLUS4;
      taken_q       <= 1'b0;
      step_q        <= 1'b0;
      c_fetch_stall <= 1'b1;
      c_br_taken    <= 1'b0;
      halted        <= START_HALTED;
      retire        <= 1'b0;
      instret       <= '0;
      err_timeout   <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      pc_q          <= c_next_pc;
      c_fetch_stall <= 1'b1;
      c_br_taken    <= 1'b0;
      halted        <= 1'b0;
      retire        <= 1'b0;

      unique case (state)
        ST_FETCH: begin
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          sel_q   <= pc_sel;
          taken_q <= br_taken;
          if (!opcode_legal(ir[6:0])) begin
            err_illegal <= 1'b1;
            state       <= ST_HALT;
            halted      <= 1'b1;
          end else if (opcode_is_mem(ir[6:0])) begin
            state <= ST_MEM_WAIT;
          end else begin
            state      <= ST_COMMIT;
            c_br_taken <= br_taken;
          end
        end

        ST_MEM_WAIT: begin
          if (memory_done) begin
            state      <= ST_COMMIT;
            c_br_taken <= taken_q;
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            state       <= ST_HALT;
            halted      <= 1'b1;
          end
        end

        ST_COMMIT: begin
          retire  <= 1'b1;
          instret <= instret + 32'd1;
          if (halt_req || step_q || (ir == EBREAK_INSTR)) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state         <= ST_FETCH;
            c_fetch_stall <= 1'b0;
          end
        end

        ST_HALT: begin
          if (run_req) begin
            step_q        <= 1'b0;
            err_timeout   <= 1'b0;
            err_illegal   <= 1'b0;
            state         <= ST_FETCH;
            c_fetch_stall <= 1'b0;
          end else if (step_req) begin
            step_q        <= 1'b1;
            state         <= ST_FETCH;
            c_fetch_stall <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end

        default: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed vector table, step/run and
// reset sequences, and randomized instructions against a transaction-level model.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int unsigned TMO = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    memory_done;
  logic [SEL_PC_WIDTH-1:0] pc_sel;
  logic                    br_taken;
  logic [31:0]             ir;
  logic [31:0]             next_pc;
  logic                    halt_req;
  logic                    run_req;
  logic                    step_req;
  logic                    c_fetch_stall;
  logic [SEL_PC_WIDTH-1:0] c_pc_sel;
  logic                    c_br_taken;
  logic [31:0]             c_next_pc;
  logic                    halted;
  logic                    retire;
  logic [31:0]             instret;
  logic                    err_timeout;
  logic                    err_illegal;

  stage_sequencer #(
    .RESET_PC    (32'h0),
    .MEM_TIMEOUT (TMO),
    .START_HALTED(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .memory_done  (memory_done),
    .pc_sel       (pc_sel),
    .br_taken     (br_taken),
    .ir           (ir),
    .next_pc      (next_pc),
    .halt_req     (halt_req),
    .run_req      (run_req),
    .step_req     (step_req),
    .c_fetch_stall(c_fetch_stall),
    .c_pc_sel     (c_pc_sel),
    .c_br_taken   (c_br_taken),
    .c_next_pc    (c_next_pc),
    .halted       (halted),
    .retire       (retire),
    .instret      (instret),
    .err_timeout  (err_timeout),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]             ir;
    logic [SEL_PC_WIDTH-1:0] sel;
    bit                      taken;
    logic [31:0]             npc;
    int                      lat;   // MEM_WAIT cycles before memory_done; >= TMO means never
    bit                      hreq;
    bit                      exp_retire;
    bit                      exp_halt;
    bit                      exp_err_t;
    bit                      exp_err_i;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instret;
  bit          m_step;
  bit          m_err_t;
  bit          m_err_i;
  bit          m_halted;

  logic [6:0] legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b0001111, 7'b1110011};

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_mem(input logic [6:0] op);
    return (op == 7'h03) || (op == 7'h23);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fill the expected-output fields of a vector from the architectural rules.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    bit legal = is_legal(v.ir[6:0]);
    bit tmo   = legal && is_mem(v.ir[6:0]) && (v.lat >= int'(TMO));
    r.exp_retire = legal && !tmo;
    r.exp_halt   = !legal || tmo || v.hreq || m_step || (v.ir == 32'h0010_0073);
    r.exp_err_t  = m_err_t || tmo;
    r.exp_err_i  = m_err_i || !legal;
    return r;
  endfunction

  // Leave HALT. mode 0 = run, 1 = step, 2 = run and step together.
  task automatic leave_halt(input int mode);
    check("halted_before_release", halted, 1'b1);
    run_req  = (mode != 1);
    step_req = (mode != 0);
    if (mode == 1) m_step = 1'b1;
    else begin
      m_step  = 1'b0;
      m_err_t = 1'b0;
      m_err_i = 1'b0;
    end
    tick();
    run_req  = 1'b0;
    step_req = 1'b0;
    m_halted = 1'b0;
    check("halted_after_release", halted, 1'b0);
    check("err_timeout_after_release", err_timeout, m_err_t);
    check("err_illegal_after_release", err_illegal, m_err_i);
  endtask

  // Entered at the negedge of a FETCH cycle; returns in FETCH or HALT.
  task automatic run_instr(input vec_t v);
    bit committed = 1'b0;
    bit legal = is_legal(v.ir[6:0]);
    ir = v.ir; pc_sel = v.sel; br_taken = v.taken; next_pc = v.npc;
    halt_req = v.hreq; memory_done = 1'b0;
    check("fetch_stall", c_fetch_stall, 1'b0);
    check("fetch_pc_hold", c_next_pc, m_pc);
    tick();
    check("exec_stall", c_fetch_stall, 1'b1);
    check("exec_retire", retire, 1'b0);
    tick();
    if (!legal) begin
      check("illegal_halted", halted, v.exp_halt);
      check("illegal_err", err_illegal, v.exp_err_i);
      check("illegal_retire", retire, v.exp_retire);
      check("illegal_pc_hold", c_next_pc, m_pc);
      m_err_i = 1'b1;
      m_halted = 1'b1;
      halt_req = 1'b0;
      return;
    end
    if (is_mem(v.ir[6:0])) begin
      for (int k = 0; k < int'(TMO); k++) begin
        check("memwait_stall", c_fetch_stall, 1'b1);
        check("memwait_retire", retire, 1'b0);
        check("memwait_pc_hold", c_next_pc, m_pc);
        if (k == v.lat) begin
          memory_done = 1'b1;
          tick();
          memory_done = 1'b0;
          committed = 1'b1;
          break;
        end
        tick();
      end
      if (!committed) begin
        check("timeout_halted", halted, v.exp_halt);
        check("timeout_err", err_timeout, v.exp_err_t);
        check("timeout_retire", retire, v.exp_retire);
        check("timeout_pc_hold", c_next_pc, m_pc);
        check("timeout_instret", instret, m_instret);
        m_err_t = 1'b1;
        m_halted = 1'b1;
        halt_req = 1'b0;
        return;
      end
    end
    check("commit_next_pc", c_next_pc, v.npc);
    check("commit_br_taken", c_br_taken, v.taken);
    check("commit_pc_sel", c_pc_sel, v.sel);
    check("commit_retire_early", retire, 1'b0);
    tick();
    halt_req = 1'b0;
    check("retire_pulse", retire, v.exp_retire);
    check("instret", instret, m_instret + 32'd1);
    check("post_commit_halted", halted, v.exp_halt);
    check("post_commit_br_taken", c_br_taken, 1'b0);
    check("post_commit_err_illegal", err_illegal, v.exp_err_i);
    check("post_commit_err_timeout", err_timeout, v.exp_err_t);
    check("post_commit_pc", c_next_pc, v.npc);
    m_pc = v.npc;
    m_instret = m_instret + 32'd1;
    m_halted = v.exp_halt;
  endtask

  vec_t tbl [10];
  vec_t rv;

  initial begin
    rst = 1'b1; memory_done = 1'b0; pc_sel = '0; br_taken = 1'b0; ir = '0;
    next_pc = '0; halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
    m_pc = 32'h0; m_instret = '0; m_step = 1'b0; m_err_t = 1'b0; m_err_i = 1'b0;
    m_halted = 1'b1;

    //                ir            sel            tk   npc       lat  hq  ret hlt et  ei
    tbl[0] = '{32'h00a0_0113, PC_SEL_PLUS4,  1'b0, 32'h0000_000c, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_a183, PC_SEL_PLUS4,  1'b0, 32'h0000_0010, 5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h0200_0063, PC_SEL_BRANCH, 1'b1, 32'h0000_0040, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h0020_a023, PC_SEL_PLUS4,  1'b0, 32'h0000_0044, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_a183, PC_SEL_PLUS4,  1'b0, 32'h0000_0048, 15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_a183, PC_SEL_PLUS4,  1'b0, 32'h0000_004c, 99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h0080_00ef, PC_SEL_BRANCH, 1'b1, 32'h0000_0060, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'hffff_ffff, PC_SEL_PLUS4,  1'b0, 32'h0000_0064, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{32'h0010_0073, PC_SEL_MTVEC,  1'b0, 32'h0000_0064, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{32'h0050_0093, PC_SEL_PLUS4,  1'b0, 32'h0000_0068, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) tick();
    check("reset_halted", halted, 1'b1);
    check("reset_stall", c_fetch_stall, 1'b1);
    check("reset_retire", retire, 1'b0);
    check("reset_instret", instret, 32'h0);
    check("reset_err_timeout", err_timeout, 1'b0);
    check("reset_err_illegal", err_illegal, 1'b0);
    check("reset_pc_sel", c_pc_sel, PC_SEL_PLUS4);
    check("reset_br_taken", c_br_taken, 1'b0);
    check("reset_pc", c_next_pc, 32'h0);
    rst = 1'b0;
    tick();
    check("start_halted_hold", halted, 1'b1);

    // Two single steps from the start-halted state, then free run.
    leave_halt(1);
    run_instr('{32'h0050_0093, PC_SEL_PLUS4, 1'b0, 32'h4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    check("between_steps_halted", halted, 1'b1);
    check("between_steps_retire", retire, 1'b0);
    leave_halt(1);
    run_instr('{32'h0050_0093, PC_SEL_PLUS4, 1'b0, 32'h8, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("two_steps_instret", instret, 32'd2);
    tick();
    check("after_steps_pc_hold", c_next_pc, 32'h8);

    for (int i = 0; i < 10; i++) begin
      if (m_halted) leave_halt((i == 6) ? 2 : 0);
      run_instr(tbl[i]);
    end

    for (int n = 0; n < 60; n++) begin
      int          cls;
      logic [31:0] rnd;
      logic [6:0]  op;
      if (m_halted) leave_halt(int'($urandom_range(0, 2)));
      cls = int'($urandom_range(0, 19));
      rnd = $urandom();
      rv.lat = 0;
      if (cls < 8)       op = legal_ops[$urandom_range(0, 4) == 0 ? 0 : 7];
      else if (cls < 11) op = ($urandom_range(0, 1) == 0) ? 7'b1100011 : 7'b1101111;
      else if (cls < 17) begin op = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23; rv.lat = int'($urandom_range(0, 10)); end
      else if (cls == 17) begin op = 7'h03; rv.lat = 40; end
      else if (cls == 18) op = 7'b1111111;
      else               op = 7'b1110011;
      rv.ir = {rnd[31:7], op};
      rv.sel = SEL_PC_WIDTH'($urandom_range(0, 4));
      rv.taken = 1'($urandom_range(0, 1));
      rnd = $urandom();
      rv.npc = {rnd[31:2], 2'b00};
      rv.hreq = ($urandom_range(0, 7) == 0);
      run_instr(predict(rv));
    end

    // Abandon a load mid MEM_WAIT with reset while an error flag is still set.
    if (m_halted) leave_halt(0);
    rv = '{32'hffff_ff80, PC_SEL_PLUS4, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_instr(predict(rv));
    leave_halt(1);
    check("step_keeps_err_illegal", err_illegal, 1'b1);
    ir = 32'h0000_a183; memory_done = 1'b0;
    repeat (4) tick();
    check("memwait_before_reset", c_fetch_stall, 1'b1);
    rst = 1'b1;
    tick();
    check("midreset_pc", c_next_pc, 32'h0);
    check("midreset_instret", instret, 32'h0);
    check("midreset_err_illegal", err_illegal, 1'b0);
    check("midreset_err_timeout", err_timeout, 1'b0);
    check("midreset_retire", retire, 1'b0);
    check("midreset_halted", halted, 1'b1);
    rst = 1'b0;
    tick();
    check("after_reset_retire", retire, 1'b0);
    check("after_reset_halted", halted, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
